// File: rtl/io_stream_loader.sv
// io_stream_loader: expands run-length tokens into fixed-width rows on a valid/ready stream
module io_stream_loader #(
  parameter int SECTION_SIZE = 4,
  parameter int ROW_SIZE = 16,
  parameter int MAX_ROWS = 16,
  localparam int PW = $clog2(ROW_SIZE) + 1,
  localparam int RW = $clog2(MAX_ROWS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load_process,
  input  logic                    i_cnn_img,
  input  logic [RW-1:0]           i_num_rows,
  input  logic                    i_interrupt,
  input  logic [SECTION_SIZE-1:0] i_input_section,
  input  logic                    i_section_valid,
  output logic                    o_section_ready,
  output logic [ROW_SIZE-1:0]     o_row_out,
  output logic                    o_row_valid,
  input  logic                    i_row_ready,
  output logic [RW-1:0]           o_row_index,
  output logic                    o_row_is_filter,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t              r_state;
  logic [ROW_SIZE-1:0] r_work;
  logic [ROW_SIZE-1:0] r_row_out;
  logic [PW-1:0]       r_ptr;
  logic [RW-1:0]       r_cnt;
  logic [RW-1:0]       r_num;
  logic [RW-1:0]       r_row_index;
  logic                r_row_valid;
  logic                r_filter;
  logic                r_error;
  logic                w_v;
  logic [PW-1:0]       w_n;
  logic [PW-1:0]       w_end;
  logic [PW-1:0]       w_rem;
  logic                w_full;
  logic                w_last;
  logic                w_acc;
  logic [RW-1:0]       w_num;
  logic [ROW_SIZE-1:0] w_fill;
  logic [ROW_SIZE-1:0] w_pre;
  assign o_section_ready = (r_state == S_RUN) && !i_interrupt && (!r_row_valid || i_row_ready);
  assign w_acc = o_section_ready && i_section_valid;
  assign w_num = (i_num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : i_num_rows;
  assign w_last = (r_cnt + RW'(1)) == r_num;
  assign o_row_out = r_row_out;
  assign o_row_valid = r_row_valid;
  assign o_row_index = r_row_index;
  assign o_row_is_filter = r_filter;
  assign o_error = r_error;
  assign o_busy = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign o_done = r_state == S_DONE;
  // decode the token and build both the filled work row and the spill pre-fill of the next row
  always_comb begin
    w_v = i_input_section[SECTION_SIZE-1];
    w_n = PW'(i_input_section[SECTION_SIZE-2:0]) + PW'(1);
    w_end = r_ptr + w_n;
    w_full = w_end >= PW'(ROW_SIZE);
    w_rem = w_end - PW'(ROW_SIZE);
    w_fill = r_work;
    w_pre = '0;
    for (int i = 0; i < ROW_SIZE; i++) begin
      w_fill[i] = (PW'(i) >= r_ptr && PW'(i) < w_end) ? w_v : r_work[i];
      w_pre[i] = (PW'(i) < w_rem) ? w_v : 1'b0;
    end
  end
  // load sequencer: start latch, token expansion, row emission, flush and done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_work <= '0;
      r_row_out <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_num <= '0;
      r_row_index <= '0;
      r_row_valid <= 1'b0;
      r_filter <= 1'b0;
      r_error <= 1'b0;
    end else if (i_interrupt) begin
      r_state <= S_IDLE;
      r_row_valid <= 1'b0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (r_row_valid && i_row_ready) r_row_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_load_process) begin
          r_filter <= i_cnn_img;
          r_num <= w_num;
          r_ptr <= '0;
          r_cnt <= '0;
          r_work <= '0;
          r_error <= 1'b0;
          r_state <= (w_num == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (w_acc) begin
          if (!w_full) begin
            r_work <= w_fill;
            r_ptr <= w_end;
          end else begin
            r_row_out <= w_fill;
            r_row_valid <= 1'b1;
            r_row_index <= r_cnt;
            r_cnt <= r_cnt + RW'(1);
            if (w_last) begin
              r_state <= S_FLUSH;
              r_error <= r_error || (w_rem != '0);
              r_work <= '0;
              r_ptr <= '0;
            end else begin
              r_work <= w_pre;
              r_ptr <= w_rem;
            end
          end
        end
        S_FLUSH: if (r_row_valid && i_row_ready) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_stream_loader.sv
// tb_io_stream_loader: directed tests against a bit-stream model of the loader
module tb_io_stream_loader;
  localparam int RW = 5;
  logic clk = 0, rst_n = 0, load = 0, cnn = 0, intr = 0, sv = 0, rr = 0;
  logic [RW-1:0] nrows = '0;
  logic [3:0] sec = '0;
  logic o_section_ready, o_row_valid, o_row_is_filter, o_busy, o_done, o_error;
  logic [15:0] o_row_out;
  logic [RW-1:0] o_row_index;
  int total = 0, bad = 0, cyc = 0, c_start = 0, c_done = 0;
  logic [15:0] exp_row[$];
  logic [RW-1:0] exp_idx[$];
  logic [3:0] toks[$];
  logic exp_err;
  logic [15:0] last_row = '0;

  io_stream_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_process(load), .i_cnn_img(cnn),
    .i_num_rows(nrows), .i_interrupt(intr), .i_input_section(sec),
    .i_section_valid(sv), .o_section_ready(o_section_ready), .o_row_out(o_row_out),
    .o_row_valid(o_row_valid), .i_row_ready(rr), .o_row_index(o_row_index),
    .o_row_is_filter(o_row_is_filter), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // every row handed to the consumer must match the model's next row
  always @(negedge clk) begin
    if (rst_n && o_row_valid && rr) begin
      chk("row_expected", 32'(exp_row.size() != 0), 1);
      if (exp_row.size() != 0) begin
        chk("row_out", o_row_out, exp_row.pop_front());
        chk("row_index", o_row_index, exp_idx.pop_front());
      end
      last_row = o_row_out;
    end
  end

  // model: flatten tokens into a bit stream, cut into rows, leftover bits mean overflow
  task automatic build(input int n);
    logic q[$];
    logic [15:0] r;
    int nr;
    exp_row.delete();
    exp_idx.delete();
    foreach (toks[i])
      for (int j = 0; j < int'(toks[i][2:0]) + 1; j++) q.push_back(toks[i][3]);
    nr = (n > 16) ? 16 : n;
    for (int k = 0; k < nr && q.size() >= 16; k++) begin
      for (int j = 0; j < 16; j++) r[j] = q.pop_front();
      exp_row.push_back(r);
      exp_idx.push_back(RW'(k));
    end
    exp_err = q.size() > 0;
  endtask

  task automatic start(input logic c, input logic [RW-1:0] n);
    load = 1; cnn = c; nrows = n;
    @(posedge clk); #1;
    load = 0;
    c_start = cyc;
  endtask

  task automatic send(input logic [3:0] t);
    logic ok;
    ok = 0;
    sec = t; sv = 1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = o_section_ready;
      @(posedge clk); #1;
    end
    sv = 0;
    chk("tok_accept", ok, 1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300 && !o_done; c++) @(negedge clk);
    c_done = cyc;
    chk("done_seen", o_done, 1);
  endtask

  task automatic run_load(input logic c, input logic [RW-1:0] n);
    start(c, n);
    foreach (toks[i]) send(toks[i]);
    wait_done();
    chk("busy_at_done", o_busy, 0);
    chk("error", o_error, exp_err);
    chk("filter", o_row_is_filter, c);
    chk("rows_left", exp_row.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_ready", o_section_ready, 0);
    chk("rst_valid", o_row_valid, 0);
    chk("rst_row", o_row_out, 0);
    chk("rst_index", o_row_index, 0);
    chk("rst_flags", {o_row_is_filter, o_busy, o_done, o_error}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // basic expansion with a held row and exact done timing
    rr = 0;
    toks = '{4'hF, 4'hF};
    build(1);
    chk("model_basic", exp_row[0], 16'hFFFF);
    start(0, 1);
    send(4'hF); send(4'hF);
    @(negedge clk);
    chk("basic_valid", o_row_valid, 1);
    chk("basic_row", o_row_out, 16'hFFFF);
    chk("basic_index", o_row_index, 0);
    chk("flush_ready_low", o_section_ready, 0);
    chk("flush_busy", o_busy, 1);
    chk("flush_no_done", o_done, 0);
    @(posedge clk); #1;
    rr = 1;
    @(negedge clk);
    @(negedge clk);
    chk("basic_done", o_done, 1);
    chk("basic_busy", o_busy, 0);
    chk("basic_error", o_error, 0);
    chk("basic_popped", o_row_valid, 0);
    @(negedge clk);
    chk("basic_done_len", o_done, 0);
    @(posedge clk); #1;

    // alternating runs
    toks = '{4'h3, 4'hB, 4'h3, 4'hB};
    build(1);
    chk("model_alt", exp_row[0], 16'hF0F0);
    run_load(0, 1);
    chk("alt_row", last_row, 16'hF0F0);

    // overflow: remainder discarded, error set and sticky
    toks = '{4'hF, 4'hB, 4'h7};
    build(1);
    chk("model_ovf_err", exp_err, 1);
    run_load(0, 1);
    chk("ovf_row", last_row, 16'h0FFF);
    repeat (3) @(negedge clk);
    chk("error_sticky", o_error, 1);
    @(posedge clk); #1;

    // boundary spill with a zero remainder
    toks = '{4'hF, 4'hB, 4'h7, 4'hF, 4'h3};
    build(2);
    chk("model_spill0", exp_row[0], 16'h0FFF);
    chk("model_spill1", exp_row[1], 16'h0FF0);
    run_load(1, 2);
    chk("spill_row1", last_row, 16'h0FF0);

    // spill of a ones remainder
    toks = '{4'hF, 4'hB, 4'hF, 4'hF, 4'h3};
    build(2);
    run_load(0, 2);
    chk("spill_ones_row1", last_row, 16'h0FFF);

    // clamp num_rows and back-to-back token throughput
    toks.delete();
    for (int i = 0; i < 32; i++) toks.push_back((i % 2 == 0) ? 4'h7 : 4'hF);
    build(20);
    chk("model_clamp_rows", exp_row.size(), 16);
    run_load(0, 20);
    chk("clamp_row", last_row, 16'hFF00);
    chk("clamp_cycles", c_done - c_start, 33);
    @(posedge clk); #1;

    // back-pressure then interrupt
    rr = 0;
    toks.delete();
    build(4);
    start(0, 4);
    send(4'hF); send(4'hF);
    sec = 4'hF; sv = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", o_section_ready, 0);
      chk("bp_valid_held", o_row_valid, 1);
    end
    chk("bp_row", o_row_out, 16'hFFFF);
    @(posedge clk); #1;
    intr = 1;
    @(posedge clk); #1;
    intr = 0; sv = 0;
    @(negedge clk);
    chk("intr_valid", o_row_valid, 0);
    chk("intr_busy", o_busy, 0);
    chk("intr_ready", o_section_ready, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= int'(o_done);
    end
    chk("intr_no_done", seen, 0);
    chk("intr_error", o_error, 0);
    @(posedge clk); #1;

    // zero rows in filter mode
    rr = 1;
    start(1, 0);
    @(negedge clk);
    chk("zero_done", o_done, 1);
    chk("zero_filter", o_row_is_filter, 1);
    chk("zero_valid", o_row_valid, 0);
    @(negedge clk);
    chk("zero_done_len", o_done, 0);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a load
    rr = 0;
    start(1, 2);
    send(4'hF); send(4'hF);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", o_row_valid, 0);
    chk("mid_rst_row", o_row_out, 0);
    chk("mid_rst_flags", {o_row_is_filter, o_busy, o_done, o_error, o_section_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen |= int'(o_done);
    end
    chk("mid_rst_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
